multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle NPC core.
- Sequences every instruction through fetch, decode, execute, optional memory access and writeback.
- Issues one-cycle enable strobes to the PC, instruction register, register file and CSR file.
- Runs req/gnt/rvalid handshakes with the instruction-fetch and load/store memory ports; a watchdog traps on a stalled bus.

Parameters:
- TIMEOUT, 255, maximum cycles in IF_WAIT or MEM_WAIT before a bus-error trap; range 1..255.
- CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- I_clk  in  1  core clock.
- I_rst_n  in  1  synchronous active-low reset.
- I_opcode  in  7  inst[6:0] from the instruction register; valid from ID onward.
- I_funct3  in  3  inst[14:12]; used only to decode SYSTEM.
- I_sys_imm  in  12  inst[31:20]; distinguishes ecall, ebreak and mret.
- O_ifu_req  out  1  fetch request.
- I_ifu_gnt  in  1  fetch request accepted.
- I_ifu_rvalid  in  1  fetch data valid.
- O_lsu_req  out  1  data request.
- O_lsu_we  out  1  1 = store, 0 = load; valid while O_lsu_req is high.
- I_lsu_gnt  in  1  data request accepted.
- I_lsu_rvalid  in  1  load data valid or store acknowledged.
- O_ir_we  out  1  latch instruction register.
- O_pc_we  out  1  update PC.
- O_rf_we  out  1  register-file write.
- O_csr_we  out  1  CSR write.
- O_trap  out  1  one-cycle trap pulse.
- O_trap_cause  out  4  cause: 2 illegal, 3 ebreak, 5 load fault, 7 store fault, 11 ecall, 1 fetch fault.
- O_retire  out  1  one-cycle pulse when an instruction completes.
- O_halt  out  1  sticky; set by ebreak.
- O_state  out  4  current state, for debug and difftest.

Behaviour:
- Reset: I_rst_n is sampled on the rising edge of I_clk; reset is synchronous and active-low.
  - State goes to IF_REQ and the watchdog counter clears.
  - Every output is 0 except O_state = IF_REQ.
  - Reset asserted in any state aborts the current instruction without any strobe; an outstanding bus transaction is simply dropped.
- State encodings: IF_REQ=0, IF_WAIT=1, ID=2, EX=3, MEM_REQ=4, MEM_WAIT=5, WB=6, TRAP=7, HALT=8.
- IF_REQ:
  - O_ifu_req=1.
  - On I_ifu_gnt, go to IF_WAIT.
  - O_ifu_req stays high until gnt; it never drops without a gnt.
- IF_WAIT:
  - On I_ifu_rvalid, assert O_ir_we in the same cycle, then go to ID.
  - I_ifu_rvalid and gnt arriving in the same cycle while in IF_REQ is not legal; rvalid is ignored outside the WAIT states.
- ID: decode I_opcode.
  - LOAD, STORE: go to EX.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH: go to EX.
  - SYSTEM: funct3=0 with imm 0x000 is ecall, 0x001 is ebreak, 0x302 is mret; funct3 != 0 is CSR access. Each goes to EX.
  - Any other opcode, or SYSTEM funct3=0 with an unlisted imm: go to TRAP with cause 2.
- EX:
  - LOAD or STORE: go to MEM_REQ.
  - ebreak: go to TRAP with cause 3.
  - ecall: go to TRAP with cause 11.
  - Everything else: go to WB.
- MEM_REQ:
  - O_lsu_req=1; O_lsu_we = (opcode == STORE).
  - On I_lsu_gnt, go to MEM_WAIT.
- MEM_WAIT: on I_lsu_rvalid, go to WB.
- WB: a single cycle, then back to IF_REQ. In this cycle:
  - O_pc_we=1 and O_retire=1.
  - O_rf_we=1 unless the opcode is STORE or BRANCH, or it is SYSTEM with funct3=0.
  - O_csr_we=1 for CSR access and for mret.
- TRAP: a single cycle.
  - O_trap=1; O_trap_cause is valid; O_pc_we=1 (PC is loaded from mtvec); O_csr_we=1 (mepc and mcause written).
  - Cause 3 (ebreak): set O_halt and go to HALT.
  - Otherwise: go to IF_REQ.
- HALT: absorbing; only reset leaves it. No strobes are issued.
- Watchdog:
  - Counter clears on entry to IF_WAIT or MEM_WAIT and increments each cycle in those states.
  - When the count equals TIMEOUT with rvalid still low, go to TRAP.
  - Cause is 1 from IF_WAIT; from MEM_WAIT it is 5 for a load and 7 for a store.
  - If rvalid arrives in the cycle the count reaches TIMEOUT, the response wins and there is no trap.
- Latency: ALU, branch and jump instructions take 5 cycles with zero-wait memory (IF_REQ, IF_WAIT, ID, EX, WB); loads and stores take 7.
- All strobes are single-cycle Moore outputs except O_ir_we, which is gated by rvalid.

Decomposition:
- Shared defines.v holds:
  - the RV32 opcode constants already used by the decoder;
  - new state encodings `CTRL_*;
  - trap cause constants `CAUSE_*;
  - SYSTEM imm constants `SYS_ECALL, `SYS_EBREAK, `SYS_MRET.
- One sub-module: ctrl_watchdog. It holds the counter, clear/enable inputs, and a timeout output.

Test Plan:
- ADDI with gnt and rvalid the cycle after each request → O_state sequence 0,1,2,3,6,0; O_rf_we=1 and O_retire=1 on cycle 5 only; O_ir_we on cycle 2.
- LW, with I_lsu_gnt delayed 3 cycles → O_lsu_req held for 4 cycles with O_lsu_we=0, then MEM_WAIT and WB with O_rf_we=1; SW gives O_lsu_we=1 and O_rf_we=0.
- Opcode 7'b0000000 → TRAP at cycle 4 with O_trap_cause=2 and O_pc_we=1, then IF_REQ; no O_retire.
- ebreak (opcode 1110011, funct3 0, imm 0x001) → O_trap_cause=3, O_halt=1; state stays 8 for 100 cycles until reset.
- TIMEOUT=4, rvalid never asserted in IF_WAIT → O_trap after 4 wait cycles with cause 1; repeat with rvalid on the 4th cycle → no trap, normal retire.
- Deassert I_rst_n during MEM_WAIT → next edge gives O_state=0 with all strobes 0; a later rvalid is ignored.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle NPC control FSM: states, RV32 opcodes,
// trap causes, SYSTEM immediates and the instruction-class decoder.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    CTRL_IF_REQ   = 4'd0,
    CTRL_IF_WAIT  = 4'd1,
    CTRL_ID       = 4'd2,
    CTRL_EX       = 4'd3,
    CTRL_MEM_REQ  = 4'd4,
    CTRL_MEM_WAIT = 4'd5,
    CTRL_WB       = 4'd6,
    CTRL_TRAP     = 4'd7,
    CTRL_HALT     = 4'd8
  } ctrl_state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] CAUSE_FETCH   = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
  localparam logic [3:0] CAUSE_LOAD    = 4'd5;
  localparam logic [3:0] CAUSE_STORE   = 4'd7;
  localparam logic [3:0] CAUSE_ECALL   = 4'd11;

  localparam logic [11:0] SYS_ECALL  = 12'h000;
  localparam logic [11:0] SYS_EBREAK = 12'h001;
  localparam logic [11:0] SYS_MRET   = 12'h302;

  typedef struct packed {
    logic legal;
    logic is_mem;
    logic is_store;
    logic is_ecall;
    logic is_ebreak;
    logic wb_rf;
    logic wb_csr;
  } dec_t;

  function automatic dec_t decode(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [11:0] imm);
    dec_t d;
    d = '0;
    case (opc)
      OPC_LOAD: begin
        d.legal  = 1'b1;
        d.is_mem = 1'b1;
        d.wb_rf  = 1'b1;
      end
      OPC_STORE: begin
        d.legal    = 1'b1;
        d.is_mem   = 1'b1;
        d.is_store = 1'b1;
      end
      OPC_BRANCH: d.legal = 1'b1;
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
        d.legal = 1'b1;
        d.wb_rf = 1'b1;
      end
      OPC_SYSTEM: begin
        if (f3 != 3'd0) begin
          d.legal  = 1'b1;
          d.wb_rf  = 1'b1;
          d.wb_csr = 1'b1;
        end else begin
          case (imm)
            SYS_ECALL: begin
              d.legal    = 1'b1;
              d.is_ecall = 1'b1;
            end
            SYS_EBREAK: begin
              d.legal     = 1'b1;
              d.is_ebreak = 1'b1;
            end
            SYS_MRET: begin
              d.legal  = 1'b1;
              d.wb_csr = 1'b1;
            end
            default: d.legal = 1'b0;
          endcase
        end
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_watchdog.sv
// Bus watchdog: counts cycles spent in a WAIT state and flags the cycle in
// which the count reaches TIMEOUT.
module multicycle_ctrl_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_clr,
  input  logic I_en,
  output logic O_timeout
);
  import multicycle_ctrl_pkg::*;

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  // w_cnt_inc is the number of wait cycles including the current one
  assign w_cnt_inc = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign O_timeout = I_en && (w_cnt_inc == CNT_W'(TIMEOUT));

  // Wait-cycle counter
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      r_cnt <= '0;
    end else if (I_clr) begin
      r_cnt <= '0;
    end else if (I_en) begin
      r_cnt <= w_cnt_inc;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle NPC core: fetch, decode, execute,
// memory access, writeback and trap sequencing with registered strobes.
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic [6:0]  I_opcode,
  input  logic [2:0]  I_funct3,
  input  logic [11:0] I_sys_imm,
  output logic        O_ifu_req,
  input  logic        I_ifu_gnt,
  input  logic        I_ifu_rvalid,
  output logic        O_lsu_req,
  output logic        O_lsu_we,
  input  logic        I_lsu_gnt,
  input  logic        I_lsu_rvalid,
  output logic        O_ir_we,
  output logic        O_pc_we,
  output logic        O_rf_we,
  output logic        O_csr_we,
  output logic        O_trap,
  output logic [3:0]  O_trap_cause,
  output logic        O_retire,
  output logic        O_halt,
  output logic [3:0]  O_state
);
  import multicycle_ctrl_pkg::*;

  ctrl_state_e r_state;
  ctrl_state_e w_next;
  logic [3:0]  w_cause;
  dec_t        w_dec;
  logic        w_in_wait;
  logic        w_timeout;

  logic       r_ifu_req, r_lsu_req, r_lsu_we, r_pc_we, r_rf_we;
  logic       r_csr_we, r_trap, r_retire, r_halt;
  logic [3:0] r_trap_cause;

  assign w_dec     = decode(I_opcode, I_funct3, I_sys_imm);
  assign w_in_wait = (r_state == CTRL_IF_WAIT) || (r_state == CTRL_MEM_WAIT);

  multicycle_ctrl_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .I_clk     (I_clk),
    .I_rst_n   (I_rst_n),
    .I_clr     (!w_in_wait),
    .I_en      (w_in_wait),
    .O_timeout (w_timeout)
  );

  // State register
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      r_state <= CTRL_IF_REQ;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and trap-cause selection
  always_comb begin
    w_next  = r_state;
    w_cause = 4'd0;
    case (r_state)
      CTRL_IF_REQ: begin
        if (I_ifu_gnt) w_next = CTRL_IF_WAIT;
        else           w_next = CTRL_IF_REQ;
      end
      CTRL_IF_WAIT: begin
        if (I_ifu_rvalid) begin
          w_next = CTRL_ID;
        end else if (w_timeout) begin
          w_next  = CTRL_TRAP;
          w_cause = CAUSE_FETCH;
        end else begin
          w_next = CTRL_IF_WAIT;
        end
      end
      CTRL_ID: begin
        if (w_dec.legal) begin
          w_next = CTRL_EX;
        end else begin
          w_next  = CTRL_TRAP;
          w_cause = CAUSE_ILLEGAL;
        end
      end
      CTRL_EX: begin
        if (w_dec.is_mem) begin
          w_next = CTRL_MEM_REQ;
        end else if (w_dec.is_ebreak) begin
          w_next  = CTRL_TRAP;
          w_cause = CAUSE_EBREAK;
        end else if (w_dec.is_ecall) begin
          w_next  = CTRL_TRAP;
          w_cause = CAUSE_ECALL;
        end else begin
          w_next = CTRL_WB;
        end
      end
      CTRL_MEM_REQ: begin
        if (I_lsu_gnt) w_next = CTRL_MEM_WAIT;
        else           w_next = CTRL_MEM_REQ;
      end
      CTRL_MEM_WAIT: begin
        if (I_lsu_rvalid) begin
          w_next = CTRL_WB;
        end else if (w_timeout) begin
          w_next  = CTRL_TRAP;
          w_cause = w_dec.is_store ? CAUSE_STORE : CAUSE_LOAD;
        end else begin
          w_next = CTRL_MEM_WAIT;
        end
      end
      CTRL_WB: w_next = CTRL_IF_REQ;
      CTRL_TRAP: begin
        // the trap cause register still holds the cause while in TRAP
        if (r_trap_cause == CAUSE_EBREAK) w_next = CTRL_HALT;
        else                              w_next = CTRL_IF_REQ;
      end
      CTRL_HALT: w_next = CTRL_HALT;
      default:   w_next = CTRL_IF_REQ;
    endcase
  end

  // Moore strobes registered from the next state so reset forces them low
  always_ff @(posedge I_clk) begin
    if (!I_rst_n) begin
      r_ifu_req    <= 1'b0;
      r_lsu_req    <= 1'b0;
      r_lsu_we     <= 1'b0;
      r_pc_we      <= 1'b0;
      r_rf_we      <= 1'b0;
      r_csr_we     <= 1'b0;
      r_trap       <= 1'b0;
      r_trap_cause <= 4'd0;
      r_retire     <= 1'b0;
      r_halt       <= 1'b0;
    end else begin
      r_ifu_req    <= (w_next == CTRL_IF_REQ);
      r_lsu_req    <= (w_next == CTRL_MEM_REQ);
      r_lsu_we     <= (w_next == CTRL_MEM_REQ) && w_dec.is_store;
      r_pc_we      <= (w_next == CTRL_WB) || (w_next == CTRL_TRAP);
      r_rf_we      <= (w_next == CTRL_WB) && w_dec.wb_rf;
      r_csr_we     <= ((w_next == CTRL_WB) && w_dec.wb_csr) || (w_next == CTRL_TRAP);
      r_trap       <= (w_next == CTRL_TRAP);
      r_trap_cause <= (w_next == CTRL_TRAP) ? w_cause : 4'd0;
      r_retire     <= (w_next == CTRL_WB);
      r_halt       <= r_halt || (w_next == CTRL_HALT);
    end
  end

  assign O_ifu_req    = r_ifu_req;
  assign O_lsu_req    = r_lsu_req;
  assign O_lsu_we     = r_lsu_we;
  assign O_ir_we      = I_rst_n && (r_state == CTRL_IF_WAIT) && I_ifu_rvalid;
  assign O_pc_we      = r_pc_we;
  assign O_rf_we      = r_rf_we;
  assign O_csr_we     = r_csr_we;
  assign O_trap       = r_trap;
  assign O_trap_cause = r_trap_cause;
  assign O_retire     = r_retire;
  assign O_halt       = r_halt;
  assign O_state      = r_state;

endmodule
